// File: rtl/uart_rx_edge_sampler.sv
// UART RX oversampling front end: edge/bit counters and centre-of-bit sampler.
// Define RX_SAMPLE_MAJ3_EN for a 3-sample majority vote around the bit centre.
module uart_rx_edge_sampler #(
  parameter int  PRESCALE = 8,
  localparam int EW       = $clog2(PRESCALE)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RX_IN,
  input  logic          enable,
  input  logic          dat_samp_en,
  output logic [EW-1:0] edge_cnt,
  output logic [3:0]    bit_cnt,
  output logic          sampled_bit,
  output logic          sample_valid
);

  localparam int HALF = PRESCALE / 2;

  localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] PT_M = EW'(HALF);

  logic wrap;
  logic at_m;
  logic cap;
  logic vote;

  assign wrap = (edge_cnt == LAST);
  assign at_m = (edge_cnt == PT_M);
  assign cap  = enable & dat_samp_en;

  // Edge index within the current bit; wraps every PRESCALE clocks
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + EW'(1);
    end
  end

  // Bit index within the frame; steps on the edge wrap, saturates at 15
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt <= 4'd0;
    end else if (!enable) begin
      bit_cnt <= 4'd0;
    end else if (wrap && (bit_cnt != 4'd15)) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

`ifdef RX_SAMPLE_MAJ3_EN
  localparam logic [EW-1:0] PT_A = EW'(HALF - 2);
  localparam logic [EW-1:0] PT_B = EW'(HALF - 1);

  logic s0;
  logic s1;

  // Early samples ahead of the centre; dropped when the frame aborts
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else if (!enable) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else if (dat_samp_en) begin
      if (edge_cnt == PT_A) s0 <= RX_IN;
      if (edge_cnt == PT_B) s1 <= RX_IN;
    end
  end

  assign vote = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
`else
  assign vote = RX_IN;
`endif

  // Recovered bit, updated only at the centre edge when capture is allowed
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit <= 1'b1;
    end else if (cap && at_m) begin
      sampled_bit <= vote;
    end
  end

  // One-cycle strobe accompanying each sampled_bit update
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= cap && at_m;
    end
  end

endmodule
